// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter sharing one operand datapath among NUM_REQ sources.
// Ports: clk, rst (sync, active-high); req/req_data from requesters;
//        gnt one-cycle capture pulse; out_valid/out_data/out_src to the ALU
//        stage, consumed when out_valid && out_ready.
module operand_mux_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] elig;
    logic               hi_found;
    logic               lo_found;
    logic [SRC_W-1:0]   hi_idx;
    logic [SRC_W-1:0]   lo_idx;
    logic [SRC_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [DATA_W-1:0]  win_data;
    logic               capture;

    // A requester sees its gnt one cycle late, so its req is masked
    // while gnt is high to avoid granting the same word twice.
    assign elig = req & ~gnt;

    // Winner search: the lowest eligible index at or above rr_ptr wins;
    // if none, the lowest eligible index overall (the wrapped part).
    // Descending loop leaves the lowest hit in each candidate.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_found = 1'b1;
                lo_idx   = SRC_W'(i);
                if (SRC_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = SRC_W'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    // Shared N:1 operand mux as a one-hot AND-OR tree.
    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = lo_found && (win_idx == SRC_W'(i));
            if (win_onehot[i]) begin
                win_data = win_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // out_ready only matters while a word is held.
    assign capture = lo_found && ((state == IDLE) || out_ready);

    assign rr_next = (win_idx == SRC_W'(NUM_REQ - 1))
                   ? '0
                   : win_idx + SRC_W'(1);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !capture) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            rr_ptr   <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else begin
            gnt <= capture ? win_onehot : '0;
            if (capture) begin
                out_data <= win_data;
                out_src  <= win_idx;
                rr_ptr   <= rr_next;
            end
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: doc/operand_mux_arbiter.md
Name: operand_mux_arbiter

Overview:
- Round-robin arbiter that shares the calculator's single operand datapath among NUM_REQ requesters.
- Requesters are keypad, memory recall and result feedback.
- Selects one requester, routes its word through the shared N:1 mux into an output register, and holds it under a valid/ready handshake until the ALU stage accepts it.
- Sits between the input sources and the ALU operand register.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, operand word width in bits.
- SRC_W, $clog2(NUM_REQ) with minimum 1, width of the source index.

Ports:
- clk  input  1  system clock; all logic acts on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until that requester's gnt is seen.
- req_data  input  NUM_REQ*DATA_W  packed words; slice i = req_data[i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  registered one-hot pulse, one cycle; word i was captured.
- out_valid  output  1  out_data holds an unconsumed word.
- out_data  output  DATA_W  registered selected word.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset (synchronous, sampled on posedge clk with rst=1):
  - out_valid=0, out_data=0, out_src=0, gnt=0, rr_ptr=0, state=IDLE.
  - rst has priority over every other event.
  - A word held mid-handshake is discarded and never delivered.
- States are IDLE (out_valid=0) and HOLD (out_valid=1).
- Eligible requests: elig = req & ~gnt.
  - A requester's req is ignored in the cycle its gnt is high; this absorbs the requester's one-cycle deassert latency.
- Winner: the first index with elig set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
- Capture event (cycle T), taken when:
  - state=IDLE and elig!=0, or
  - state=HOLD and out_ready=1 and elig!=0.
- On capture, at T+1:
  - out_data = req_data slice of the winner as sampled at T.
  - out_src = winner.
  - gnt = one-hot(winner).
  - out_valid=1 and state=HOLD.
  - rr_ptr = (winner+1) mod NUM_REQ.
- Latency: request to out_valid is 1 cycle.
- In HOLD with out_ready=0: out_data, out_src and out_valid stay stable; gnt=0; no new capture.
  - Requests may change freely without affecting the held word.
- In HOLD with out_ready=1:
  - If elig=0: go to IDLE at T+1 with out_valid=0; out_data and out_src retain their last values.
  - If elig!=0: back-to-back capture, so throughput is 1 word per cycle.
- gnt is high for exactly one cycle per captured word and is 0 in all other cycles.
- out_ready is ignored while out_valid=0.
- Wrap-around: rr_ptr wraps NUM_REQ-1 -> 0.
  - With all requesters continuously requesting, grants cycle 0,1,...,NUM_REQ-1,0,...
  - No requester is starved longer than NUM_REQ-1 grants.
- Single requester active: it wins every capture regardless of rr_ptr.
- Non-power-of-two NUM_REQ: indices >= NUM_REQ are never produced; rr_ptr never exceeds NUM_REQ-1.
- Purely synchronous; no combinational path from any input to any output.

Test Plan:
- Reset: assert rst for 2 cycles while req=2'b11 -> out_valid=0, gnt=0, out_data=0, out_src=0. Release -> first grant goes to index 0.
- Single request, NUM_REQ=2: req=2'b10 with slice1=8'hA5 at T, out_ready=1 -> at T+1 out_valid=1, out_data=8'hA5, out_src=1, gnt=2'b10. At T+2 (req dropped) -> out_valid=0.
- Backpressure: word 8'h3C held with out_ready=0 for 5 cycles while req toggles -> out_data=8'h3C and out_valid=1 every cycle, gnt=0. Raise out_ready -> one acceptance, then a new capture or IDLE.
- Fairness: req=2'b11 held with out_ready=1, slice0=8'h11, slice1=8'h22 -> out_src sequence 0,1,0,1; out_data 11,22,11,22; one word per cycle; a requester whose gnt is high that cycle is not regranted.
- Wrap, NUM_REQ=3: after a grant to 2, req=3'b101 -> next grant is 0, then 2.
- Reset mid-operation: rst during HOLD with out_ready=0 -> next cycle out_valid=0 and the held word never appears; rr_ptr=0.
